// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with valid/ready flow control, flush and an optional
// 2-entry skid buffer. The control bundle is forced to zero whenever no valid entry is held.
module pipe_stage_elastic #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] STALL_MAX = '1;
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_q,   in_ready_d;
    logic [1:0]        occ_q,        occ_d;
    logic [CNT_W-1:0]  stall_q,      stall_d;
    logic              accept_s;
    logic              issue_s;

    // Without a skid slot the stage may take a new entry whenever the held one leaves this cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);
    assign accept_s  = in_valid & in_ready;
    assign issue_s   = main_valid_q & out_ready;

    assign out_valid = main_valid_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    // Next-state for both slots; flush wins over issue and accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else if (issue_s) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (accept_s) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end
        end else if (accept_s) begin
            if (main_valid_q && (SKID != 0)) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end
        end else begin
            main_valid_d = main_valid_q;
        end
        in_ready_d = ~skid_valid_d;
        occ_d      = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // Saturating count of cycles where a valid entry is held back by downstream.
    always_comb begin
        if (main_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
            occ_q        <= 2'd0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            occ_q        <= occ_d;
            stall_q      <= stall_d;
        end
    end

endmodule
